ahb_bus_arbiter: RTL and testbench

// - AMBA2 AHB arbiter: shares one AHB bus among NUM_MASTERS masters.
// - Issues HGRANT, drives HMASTER/HMASTLOCK for the address/data muxes.
// - Honours fixed-length bursts, undefined INCR bursts, locked transfers and a default master.
// - Sits between master request lines and the bus mux; it is the DUT for the bus-request,

---
 rtl/ahb_bus_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter - AMBA2 AHB bus arbiter.
// Shares one AHB bus among NUM_MASTERS masters. It drives a registered one-hot
// HGRANT, and the HMASTER/HMASTLOCK signals that steer the address and data muxes.
// It handles fixed-length bursts, undefined-length INCR bursts, locked transfers
// and a default master that owns the bus when no master is requesting.
//
// Build option: define ARB_ROUND_ROBIN_EN to select round-robin priority.
// When the macro is left undefined, fixed priority applies and the lowest index wins.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)  // derived; leave at default
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  // HTRANS encodings.
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BU_SINGLE = 3'b000;

  localparam logic [NUM_MASTERS-1:0] ONE           = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = ONE << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEFAULT_IDX   = MW'(DEFAULT_MASTER);

  typedef enum logic [1:0] {
    ST_IDLE,   // default master parked on the bus, nobody requesting
    ST_OWN,    // single / INCR owner
    ST_BURST,  // fixed-length burst in progress, beat counter active
    ST_LOCK    // owner holds the bus while its HLOCK stays high
  } state_t;

  // Return the beat count of a fixed-length burst. Return 0 for SINGLE or INCR.
  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    logic [4:0] len;
    len = 5'd0;
    case (burst)
      3'b010, 3'b011: len = 5'd4;   // WRAP4 / INCR4
      3'b100, 3'b101: len = 5'd8;   // WRAP8 / INCR8
      3'b110, 3'b111: len = 5'd16;  // WRAP16 / INCR16
      default:        len = 5'd0;
    endcase
    return len;
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  state_t                 w_rearb_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [NUM_MASTERS-1:0] w_grant_nxt;
  logic [MW-1:0]          r_owner;        // index of the granted master
  logic [MW-1:0]          w_owner_nxt;
  logic [MW-1:0]          r_master;
  logic                   r_mastlock;
  logic [4:0]             r_beat_cnt;
  logic [4:0]             w_beat_cnt_nxt;
  logic [4:0]             r_burst_len;
  logic [4:0]             w_burst_len_nxt;
  logic [MW-1:0]          w_winner;
  int                     w_rr_best;

  logic w_trans_idle;
  logic w_accept;
  logic w_nonseq_acc;
  logic w_single_acc;
  logic w_start_burst;
  logic w_owner_req;
  logic w_owner_lock;
  logic w_any_req;
  logic w_handover_beat;
  logic w_last_beat;
  logic w_early_term;
  logic w_rearb;

  // A beat counts only when the slave completes it and it carries real data.
  // BUSY and IDLE beats never count.
  assign w_trans_idle  = (HTRANS == TR_IDLE);
  assign w_accept      = HREADY && ((HTRANS == TR_NONSEQ) || (HTRANS == TR_SEQ));
  assign w_nonseq_acc  = w_accept && (HTRANS == TR_NONSEQ);
  assign w_single_acc  = w_nonseq_acc && (HBURST == BU_SINGLE);
  assign w_start_burst = w_nonseq_acc && (burst_len(HBURST) != 5'd0);
  assign w_owner_req   = HBUSREQ[r_owner];
  assign w_owner_lock  = HLOCK[r_owner];
  assign w_any_req     = |HBUSREQ;

  // Grant moves when beat L-2 is accepted. The old owner still issues the last beat,
  // because HMASTER follows HGRANT one ready edge later.
  assign w_handover_beat = (r_state == ST_BURST) && w_accept && (HTRANS == TR_SEQ) &&
                           (r_beat_cnt == r_burst_len - 5'd2);
  assign w_last_beat     = (r_state == ST_BURST) && w_accept && (HTRANS == TR_SEQ) &&
                           (r_beat_cnt == r_burst_len - 5'd1);
  // An IDLE or a new NONSEQ in the middle of a burst ends the burst early.
  assign w_early_term    = (r_state == ST_BURST) && HREADY &&
                           (w_trans_idle || (HTRANS == TR_NONSEQ));

  // A held lock blocks every rearbitration, whatever the state.
  // In LOCK, rearbitration happens only once the owner releases HLOCK.
  assign w_rearb = HREADY && !w_owner_lock &&
                   ((r_state == ST_IDLE) || (r_state == ST_LOCK) ||
                    ((r_state == ST_OWN)   && (w_trans_idle || w_single_acc || !w_owner_req)) ||
                    ((r_state == ST_BURST) && (w_trans_idle || w_nonseq_acc || w_handover_beat)));

  // Pick the next owner from the current requests. DEFAULT_MASTER wins when nobody asks.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    w_winner  = DEFAULT_IDX;
    w_rr_best = NUM_MASTERS;
`ifdef ARB_ROUND_ROBIN_EN
    // Distance 0 is the master just after the current owner. The owner itself is last.
    // The owner index doubles as the round-robin pointer: it moves only when the grant moves.
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (HBUSREQ[i] && (((i + NUM_MASTERS - 1 - int'(r_owner)) % NUM_MASTERS) < w_rr_best)) begin
        w_rr_best = (i + NUM_MASTERS - 1 - int'(r_owner)) % NUM_MASTERS;
        w_winner  = MW'(i);
      end
    end
`else
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (HBUSREQ[i]) begin
        w_winner = MW'(i);
      end
    end
`endif
  end

  // Choose the state to enter after a rearbitration.
  // A re-granted owner that starts a fixed burst at the same edge goes straight to BURST.
  always_comb begin
    w_rearb_state = ST_OWN;
    if (!w_any_req) begin
      w_rearb_state = ST_IDLE;
    end else if ((w_winner == r_owner) && w_start_burst) begin
      w_rearb_state = ST_BURST;
    end
  end

  // FSM state register.
  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (HRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_owner_lock)  w_state_nxt = ST_LOCK;
        else if (w_rearb)  w_state_nxt = w_rearb_state;
      end
      ST_OWN: begin
        if (w_owner_lock)       w_state_nxt = ST_LOCK;
        else if (w_rearb)       w_state_nxt = w_rearb_state;
        else if (w_start_burst) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (w_rearb)                          w_state_nxt = w_rearb_state;
        else if (w_early_term || w_last_beat) w_state_nxt = ST_OWN;
      end
      ST_LOCK: begin
        if (w_rearb) w_state_nxt = w_rearb_state;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output logic: next grant, owner and beat-counter values.
  always_comb begin
    w_grant_nxt     = r_grant;
    w_owner_nxt     = r_owner;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_burst_len_nxt = r_burst_len;

    if (w_rearb) begin
      w_grant_nxt = ONE << w_winner;
      w_owner_nxt = w_winner;
    end

    // When HREADY is low, nothing is accepted and the state stays put, so the counter holds.
    if (w_state_nxt != ST_BURST) begin
      w_beat_cnt_nxt = 5'd0;
    end else if (w_start_burst) begin
      w_beat_cnt_nxt  = 5'd1;
      w_burst_len_nxt = burst_len(HBURST);
    end else if (w_accept) begin
      w_beat_cnt_nxt = r_beat_cnt + 5'd1;
    end
  end

  // Grant and counter registers. HMASTER/HMASTLOCK change only on ready edges.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_grant     <= DEFAULT_GRANT;
      r_owner     <= DEFAULT_IDX;
      r_master    <= DEFAULT_IDX;
      r_mastlock  <= 1'b0;
      r_beat_cnt  <= 5'd0;
      r_burst_len <= 5'd0;
    end else begin
      r_grant     <= w_grant_nxt;
      r_owner     <= w_owner_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_burst_len <= w_burst_len_nxt;
      if (HREADY) begin
        r_master   <= r_owner;
        r_mastlock <= HLOCK[r_owner];
      end
    end
  end

  assign HGRANT    = r_grant;
  assign HMASTER   = r_master;
  assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter - directed, table-driven bench for ahb_bus_arbiter (4 masters, default 0).
module tb_ahb_bus_arbiter;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_SINGLE = 3'b000;
  localparam logic [2:0] BU_INCR4  = 3'b011;
  localparam logic [2:0] BU_INCR8  = 3'b101;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [3:0] exp_grant;
    logic [1:0] exp_master;
    logic       exp_mlock;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic [1:0] trans,
                       input logic [2:0] burst, input logic ready);
    HBUSREQ = req;
    HLOCK   = lock;
    HTRANS  = trans;
    HBURST  = burst;
    HREADY  = ready;
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset(input string tag, input logic [3:0] req, input logic [3:0] lock);
    HRESET = 1'b1;
    drive(req, lock, TR_IDLE, BU_SINGLE, 1'b1);
    step();
    HRESET = 1'b0;
    check({tag, " reset grant"},  HGRANT,    4'b0001);
    check({tag, " reset master"}, HMASTER,   2'd0);
    check({tag, " reset mlock"},  HMASTLOCK, 1'b0);
  endtask

  int exp_seq[5];

  initial begin
    // Reset with HBUSREQ=1010, then an INCR4 by M1 that hands over to M2 at beat 2.
    //          rst   req      lock     trans      burst      rdy   grant    mst   mlk
    vecs[0] = '{1'b1, 4'b1010, 4'b0000, TR_IDLE,   BU_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0};
    vecs[1] = '{1'b0, 4'b1010, 4'b0000, TR_IDLE,   BU_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0};
    vecs[2] = '{1'b0, 4'b0010, 4'b0000, TR_IDLE,   BU_SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0};
    vecs[3] = '{1'b0, 4'b0110, 4'b0000, TR_NONSEQ, BU_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0};
    vecs[4] = '{1'b0, 4'b0100, 4'b0000, TR_SEQ,    BU_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0};
    vecs[5] = '{1'b0, 4'b0100, 4'b0000, TR_SEQ,    BU_INCR4,  1'b1, 4'b0100, 2'd1, 1'b0};
    vecs[6] = '{1'b0, 4'b0100, 4'b0000, TR_SEQ,    BU_INCR4,  1'b1, 4'b0100, 2'd2, 1'b0};
    vecs[7] = '{1'b0, 4'b0100, 4'b0000, TR_IDLE,   BU_SINGLE, 1'b1, 4'b0100, 2'd2, 1'b0};
    vecs[8] = '{1'b0, 4'b0000, 4'b0000, TR_IDLE,   BU_SINGLE, 1'b1, 4'b0001, 2'd2, 1'b0};
    vecs[9] = '{1'b0, 4'b0000, 4'b0000, TR_IDLE,   BU_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0};

    HRESET = 1'b1;
    drive(4'b0000, 4'b0000, TR_IDLE, BU_SINGLE, 1'b1);

    for (int i = 0; i < 10; i++) begin
      HRESET = vecs[i].rst;
      drive(vecs[i].req, vecs[i].lock, vecs[i].trans, vecs[i].burst, vecs[i].ready);
      step();
      check($sformatf("vec%0d grant", i),  HGRANT,    vecs[i].exp_grant);
      check($sformatf("vec%0d master", i), HMASTER,   vecs[i].exp_master);
      check($sformatf("vec%0d mlock", i),  HMASTLOCK, vecs[i].exp_mlock);
      check($sformatf("vec%0d onehot", i), 32'($onehot(HGRANT)), 32'd1);
    end
    HRESET = 1'b0;

    // Idle hold: no requests for 10 cycles keeps the default master parked.
    do_reset("idle", 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("idle%0d grant", i),  HGRANT,  4'b0001);
      check($sformatf("idle%0d master", i), HMASTER, 2'd0);
    end

    // INCR4 with beat 1 stalled for 3 cycles: handover still waits for beat 2.
    do_reset("stall", 4'b0010, 4'b0000);
    step();
    check("stall grant m1", HGRANT, 4'b0010);
    step();
    check("stall master m1", HMASTER, 2'd1);
    drive(4'b0110, 4'b0000, TR_NONSEQ, BU_INCR4, 1'b1);
    step();
    check("stall beat0 grant", HGRANT, 4'b0010);
    drive(4'b0100, 4'b0000, TR_SEQ, BU_INCR4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall wait%0d grant", i),  HGRANT,  4'b0010);
      check($sformatf("stall wait%0d master", i), HMASTER, 2'd1);
    end
    HREADY = 1'b1;
    step();
    check("stall beat1 grant", HGRANT, 4'b0010);
    step();
    check("stall beat2 grant", HGRANT, 4'b0100);
    check("stall beat2 master", HMASTER, 2'd1);
    step();
    check("stall beat3 master", HMASTER, 2'd2);

    // Locked singles by M2 while M0 requests; M0 wins one edge after the lock drops.
    do_reset("lock", 4'b0100, 4'b0100);
    step();
    check("lock grant m2", HGRANT, 4'b0100);
    check("lock mlock pre", HMASTLOCK, 1'b0);
    step();
    check("lock master m2", HMASTER, 2'd2);
    check("lock mlock set", HMASTLOCK, 1'b1);
    drive(4'b0101, 4'b0100, TR_NONSEQ, BU_SINGLE, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("lock single%0d grant", i), HGRANT,    4'b0100);
      check($sformatf("lock single%0d mlock", i), HMASTLOCK, 1'b1);
    end
    drive(4'b0001, 4'b0000, TR_IDLE, BU_SINGLE, 1'b1);
    step();
    check("lock release grant", HGRANT, 4'b0001);
    check("lock release mlock", HMASTLOCK, 1'b0);

    // INCR8 ended early by IDLE: no handover at beat 2, immediate handover on IDLE.
    do_reset("early", 4'b0010, 4'b0000);
    step();
    step();
    check("early master m1", HMASTER, 2'd1);
    drive(4'b0110, 4'b0000, TR_NONSEQ, BU_INCR8, 1'b1);
    step();
    drive(4'b0100, 4'b0000, TR_SEQ, BU_INCR8, 1'b1);
    step();
    check("early beat1 grant", HGRANT, 4'b0010);
    step();
    check("early beat2 grant", HGRANT, 4'b0010);
    drive(4'b0100, 4'b0000, TR_IDLE, BU_SINGLE, 1'b1);
    step();
    check("early term grant", HGRANT, 4'b0100);

    // All four request with SINGLE transfers: priority order of grants.
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{1, 2, 3, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 0};
`endif
    do_reset("prio", 4'b1111, 4'b0000);
    drive(4'b1111, 4'b0000, TR_NONSEQ, BU_SINGLE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("prio%0d grant", i), HGRANT, 32'(4'b0001 << exp_seq[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
